// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Adds or subtracts two WIDTH-bit operands one nibble per cycle through a
//   single 4-bit ripple-carry slice. The carry is registered between nibbles.
//   Optional feature macro: ADD_OVF_EN (signed overflow flag on ovf).
//   Without ADD_OVF_EN the ovf port is tied to 0.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready is high only in IDLE. out_valid is high only in DONE,
//   and sum/cout/ovf are held stable while out_valid is high and out_ready is low.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;       // already inverted for subtract
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    count;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       slice;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)      state_nxt = RUN;
      RUN:  if (count == LAST) state_nxt = DONE;
      DONE: if (out_ready)     state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // The shared 4-bit slice: current nibble of A and B plus the carry register
  always_comb begin
    a_nib = a_q[{count, 2'b00} +: 4];
    b_nib = b_q[{count, 2'b00} +: 4];
    slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
  end

  // Operand capture, nibble-wise sum accumulation and carry chaining
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub ? 1'b1 : cin;
            count   <= '0;
          end
        end
        RUN: begin
          sum_q[{count, 2'b00} +: 4] <= slice[3:0];
          carry_q                    <= slice[4];
          if (count != LAST) begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADD_OVF_EN
  logic ovf_q;
  logic msb_cin;

  // Carry into the MSB, recovered from the top nibble's bits and result bit
  assign msb_cin = a_nib[3] ^ b_nib[3] ^ slice[3];

  // Signed overflow captured on the last nibble step, alongside the carry-out
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && count == LAST) begin
      ovf_q <= msb_cin ^ slice[4];
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl (WIDTH=16). Honours ADD_OVF_EN when defined.
module tb_nibble_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic [1:0]    dbg_state;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // entry layout: {sum, cout, ovf}
  logic [W+1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

`ifdef ADD_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: retire on every output handshake
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got sum=0x%0h cout=%0b, expected nothing", sum, cout);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        if ({sum, cout, ovf} !== e) begin
          n_fail++;
          $display("FAIL result: got sum=0x%0h cout=%0b ovf=%0b expected sum=0x%0h cout=%0b ovf=%0b",
                   sum, cout, ovf, e[W+1:2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_idle_timeout"}, {31'd0, in_ready}, 32'd1);
  endtask

  // issue one op, push expected, check out_valid latency
  task automatic do_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vcin, input logic vsub,
                       input logic [W-1:0] esum, input logic ecout, input logic eovf);
    wait_idle(name);
    a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
    exp_q.push_back({esum, ecout, eovf & OVF_ON});
    @(posedge clk); #1;             // accept edge T
    in_valid = 1'b0;
    check({name, "_in_ready_run"}, {31'd0, in_ready}, 32'd0);
    for (int k = 1; k <= NIB; k++) begin
      @(posedge clk); #1;
      if (k < NIB) check({name, "_early_valid"}, {31'd0, out_valid}, 32'd0);
      else         check({name, "_latency"},     {31'd0, out_valid}, 32'd1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum",       {16'd0, sum},       32'd0);
    check("rst_cout",      {31'd0, cout},      32'd0);
    check("rst_ovf",       {31'd0, ovf},       32'd0);
    check("rst_state",     {30'd0, dbg_state}, 32'd0);

    // directed vectors
    do_op("add_basic",  16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    do_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_pos",    16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    do_op("add_cin",    16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
    do_op("sub_cinign", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0);
    do_op("ovf_pos",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("ovf_neg",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    do_op("ovf_sub",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // back-pressure: result held, new operands dropped
    wait_idle("bp_pre");
    out_ready = 1'b0;
    do_op("bp", 16'hA5A5, 16'h1111, 1'b0, 1'b0, 16'hB6B6, 1'b0, 1'b0);
    a = 16'h0F0F; b = 16'h0101; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_sum_hold",  {16'd0, sum},       32'h0000B6B6);
      check("bp_cout_hold", {31'd0, cout},      32'd0);
      check("bp_valid",     {31'd0, out_valid}, 32'd1);
      check("bp_in_ready",  {31'd0, in_ready},  32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;             // retire edge
    check("bp_idle_ready", {31'd0, in_ready},  32'd1);
    check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    check("bp_idle_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    check("bp_no_restart", {30'd0, dbg_state}, 32'd0);

    // reset during the second RUN cycle
    wait_idle("rst_run_pre");
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;             // accept edge T
    in_valid = 1'b0;
    @(posedge clk); #1;             // edge T+1, first nibble done
    reset = 1'b1;
    @(posedge clk); #1;             // reset sampled
    reset = 1'b0;
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_sum",   {16'd0, sum},       32'd0);
    check("abort_ready", {31'd0, in_ready},  32'd1);
    do_op("post_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // drain
    begin
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
    end
    check("queue_drained", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
